// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults and lock FSM state type for the memory port arbiter.
//   ARB_DATA_WIDTH / ARB_ADDR_WIDTH / ARB_NUM_REQ / ARB_LOCK_MAX : default parameter values
//   arb_state_e : lock FSM states (ARB_IDLE, ARB_LOCKED)
package mem_arb_pkg;
    localparam int ARB_DATA_WIDTH = 32;
    localparam int ARB_ADDR_WIDTH = 10;
    localparam int ARB_NUM_REQ    = 2;
    localparam int ARB_LOCK_MAX   = 16;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select.
//   req : request vector
//   ptr : index where the search starts (moves upward, wraps)
//   gnt : one-hot grant, all zero when no request is high
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest requester above ptr wins.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with burst lock, sharing one 1-cycle-latency memory port.
//   clk, rst_n            : clock, synchronous active-low reset
//   req/lock/we           : per-requester request, keep-grant request, write select
//   addr/wdata            : per-requester packed word address and write data
//   gnt                   : combinational one-hot grant (accepted when req & gnt at an edge)
//   rvalid/rdata          : one-hot read-valid two cycles after grant, shared read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : registered memory command, memory read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int LOCK_MAX   = ARB_LOCK_MAX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e          state;
    logic [PW-1:0]       ptr, owner, gidx, tag1;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  pick;
    logic                acc, tag1_v;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.req(req), .ptr(ptr), .gnt(pick));

    // While locked only the owner may win; the round-robin pick is ignored.
    assign gnt   = !rst_n ? '0 : (state == ARB_LOCKED) ? (req & (ONE << owner)) : pick;
    assign acc   = |gnt;
    // Memory answers one cycle after the command, which lines up with the registered rvalid.
    assign rdata = |rvalid ? mem_rdata : '0;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) gidx = PW'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag1_v    <= 1'b0;
            tag1      <= '0;
            rvalid    <= '0;
        end else begin
            mem_en <= acc;
            mem_we <= acc & we[gidx];
            tag1_v <= acc & ~we[gidx];
            tag1   <= gidx;
            rvalid <= tag1_v ? (ONE << tag1) : '0;
            if (acc) begin
                mem_addr  <= addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
                // Also yields owner+1 on a forced lock release, since the last beat is a grant.
                ptr       <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            if (state == ARB_IDLE) begin
                if (acc && lock[gidx] && LOCK_MAX > 1) begin
                    state <= ARB_LOCKED;
                    owner <= gidx;
                    cnt   <= CW'(1);
                end
            end else if (acc && lock[owner] && int'(cnt) + 1 < LOCK_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                state <= ARB_IDLE;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, hand sequences and a scoreboarded random run for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LM = 16;
    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'h2222_0000;
    localparam logic [DW-1:0] DB = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, lock, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem [0:1023] = '{default: '0};
    int              tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: 1-cycle read latency, read data forced to 0 during reset, contents kept.
    always @(posedge clk) begin
        if (!rst_n) mem_rdata <= '0;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] r, l, w, input logic [AW-1:0] a0, a1,
                         input logic [DW-1:0] d0, d1);
        req = r; lock = l; we = w; addr = {a1, a0}; wdata = {d1, d0};
    endtask

    typedef struct {
        logic [N-1:0]  req, we;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [N-1:0]  gnt;
        logic          en, mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic [N-1:0]  rv;
        logic [DW-1:0] rd;
    } vec_t;
    vec_t tbl [14];

    // Random-phase state
    logic [N-1:0]  pend, r_we, r_lock;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_wd [N];
    int            waitg [N];
    logic [DW-1:0] ref_mem [0:15] = '{default: '0};
    logic          p1_v, p2_v;
    int            p1_i, p2_i;
    logic [DW-1:0] p1_d, p2_d;

    task automatic new_txn(input int i, input int ph);
        pend[i]   = 1'b1;
        r_we[i]   = 1'($urandom_range(1));
        r_addr[i] = AW'(10'h100 + $urandom_range(15));
        r_wd[i]   = $urandom;
        r_lock[i] = (ph == 0) ? 1'b0 : r_lock[i] ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
    endtask

    task automatic rand_cycle(input int ph, input bit gen);
        logic [N-1:0] expv;
        int bound;
        bound = (ph == 0) ? N : LM + N;
        if (gen)
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(15) < ((ph != 0 && r_lock[i]) ? 15 : 10)) new_txn(i, ph);
        req = pend; lock = r_lock & pend; we = r_we;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = r_addr[i];
            wdata[i*DW +: DW] = r_wd[i];
        end
        #1;
        expv = '0;
        if (p2_v) expv[p2_i] = 1'b1;
        chk("rand rvalid", rvalid, expv);
        if (p2_v) chk("rand rdata", rdata, p2_d);
        chk("rand gnt legal", ((gnt & ~req) == '0) && $onehot0(gnt), 1);
        p2_v = p1_v; p2_i = p1_i; p2_d = p1_d;
        p1_v = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && req[i]) begin
                chk($sformatf("rand wait r%0d", i), waitg[i] <= bound, 1);
                if (r_we[i]) ref_mem[r_addr[i][3:0]] = r_wd[i];
                else begin
                    p1_v = 1'b1; p1_i = i; p1_d = ref_mem[r_addr[i][3:0]];
                end
                waitg[i] = 0;
                pend[i]  = 1'b0;
                for (int j = 0; j < N; j++) if (j != i && pend[j]) waitg[j]++;
            end
        end
        step();
    endtask

    initial begin
        int run;
        tbl[0]  = '{2'b11, 2'b11, 10'h011, 10'h022, D0, D1, 2'b01, 1'b0, 1'b0, 10'h000, '0, 2'b00, '0};
        tbl[1]  = '{2'b11, 2'b11, 10'h011, 10'h022, D0, D1, 2'b10, 1'b1, 1'b1, 10'h011, D0, 2'b00, '0};
        tbl[2]  = '{2'b11, 2'b11, 10'h011, 10'h022, D0, D1, 2'b01, 1'b1, 1'b1, 10'h022, D1, 2'b00, '0};
        tbl[3]  = '{2'b11, 2'b11, 10'h011, 10'h022, D0, D1, 2'b10, 1'b1, 1'b1, 10'h011, D0, 2'b00, '0};
        tbl[4]  = '{2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, 1'b1, 1'b1, 10'h022, D1, 2'b00, '0};
        tbl[5]  = '{2'b01, 2'b01, 10'h03A, 10'h000, DB, '0, 2'b01, 1'b0, 1'b0, 10'h000, '0, 2'b00, '0};
        tbl[6]  = '{2'b10, 2'b00, 10'h000, 10'h03A, '0, '0, 2'b10, 1'b1, 1'b1, 10'h03A, DB, 2'b00, '0};
        tbl[7]  = '{2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, 1'b1, 1'b0, 10'h03A, '0, 2'b00, '0};
        tbl[8]  = '{2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, 1'b0, 1'b0, 10'h000, '0, 2'b10, DB};
        tbl[9]  = '{2'b01, 2'b00, 10'h011, 10'h000, '0, '0, 2'b01, 1'b0, 1'b0, 10'h000, '0, 2'b00, '0};
        tbl[10] = '{2'b10, 2'b00, 10'h000, 10'h022, '0, '0, 2'b10, 1'b1, 1'b0, 10'h011, '0, 2'b00, '0};
        tbl[11] = '{2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, 1'b1, 1'b0, 10'h022, '0, 2'b01, D0};
        tbl[12] = '{2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, 1'b0, 1'b0, 10'h000, '0, 2'b10, D1};
        tbl[13] = '{2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, 1'b0, 1'b0, 10'h000, '0, 2'b00, '0};

        // Reset state with requests pending
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 2'b11, 10'h3FF, 10'h3FF, '1, '1);
        repeat (3) step();
        #1;
        chk("reset gnt", gnt, 0);
        chk("reset mem_en", mem_en, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset rvalid", rvalid, 0);
        chk("reset rdata", rdata, 0);

        // Reset in the cycle after a read grant discards it; first post-reset grant is immediate
        rst_n = 1'b1;
        drive(2'b01, 2'b00, 2'b00, 10'h03A, 10'h000, '0, '0);
        #1 chk("release gnt", gnt, 2'b01);
        step();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0);
        step();
        #1;
        chk("midreset rvalid", rvalid, 0);
        chk("midreset mem_en", mem_en, 0);
        step();
        #1 chk("midreset rvalid late", rvalid, 0);
        rst_n = 1'b1;
        drive(2'b01, 2'b00, 2'b00, 10'h03A, 10'h000, '0, '0);
        #1 chk("post-reset gnt", gnt, 2'b01);
        step();
        #1;
        chk("post-reset mem_en", mem_en, 1);
        chk("post-reset mem_addr", mem_addr, 10'h03A);
        drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0);
        step();
        #1;
        chk("post-reset rvalid", rvalid, 2'b01);
        chk("post-reset rdata", rdata, 0);

        // Fresh reset, then the vector table
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            drive(tbl[k].req, 2'b00, tbl[k].we, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1);
            #1;
            chk($sformatf("v%0d gnt", k), gnt, tbl[k].gnt);
            chk($sformatf("v%0d mem_en", k), mem_en, tbl[k].en);
            chk($sformatf("v%0d mem_we", k), mem_we, tbl[k].mwe);
            if (tbl[k].en) chk($sformatf("v%0d mem_addr", k), mem_addr, tbl[k].maddr);
            if (tbl[k].en && tbl[k].mwe) chk($sformatf("v%0d mem_wdata", k), mem_wdata, tbl[k].mwd);
            chk($sformatf("v%0d rvalid", k), rvalid, tbl[k].rv);
            if (tbl[k].rv != '0) chk($sformatf("v%0d rdata", k), rdata, tbl[k].rd);
            step();
        end

        // Lock held by requester 1 against a competing requester 0: 16 beats, then forced release
        drive(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, '0, '0);
        #1 chk("prelock gnt", gnt, 2'b01);
        step();
        drive(2'b11, 2'b10, 2'b00, 10'h005, 10'h006, '0, '0);
        run = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (gnt != 2'b10) break;
            run++;
            step();
        end
        chk("lock run length", run, LM);
        chk("lock release gnt", gnt, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0);
        step();

        // Idle cycles leave the pointer alone
        drive(2'b01, 2'b00, 2'b00, 10'h007, 10'h000, '0, '0);
        #1 chk("preidle gnt", gnt, 2'b01);
        step();
        drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0);
        step();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("idle%0d mem_en", k), mem_en, 0);
            chk($sformatf("idle%0d gnt", k), gnt, 0);
            step();
        end
        drive(2'b11, 2'b00, 2'b00, 10'h007, 10'h008, '0, '0);
        #1 chk("idle ptr held", gnt, 2'b10);
        drive(2'b10, 2'b00, 2'b00, 10'h007, 10'h008, '0, '0);
        #1 chk("idle req10 gnt", gnt, 2'b10);
        step();

        // Owner releases by deasserting lock
        drive(2'b11, 2'b01, 2'b00, 10'h009, 10'h00A, '0, '0);
        #1 chk("lockdrop first gnt", gnt, 2'b01);
        step();
        #1 chk("lockdrop locked gnt", gnt, 2'b01);
        step();
        drive(2'b11, 2'b00, 2'b00, 10'h009, 10'h00A, '0, '0);
        #1 chk("lockdrop last beat gnt", gnt, 2'b01);
        step();
        #1 chk("lockdrop after gnt", gnt, 2'b10);
        drive(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0);
        repeat (3) step();

        // Random traffic with a scoreboard: unlocked phase, then locked phase, then drain
        pend = '0; r_we = '0; r_lock = '0;
        p1_v = 1'b0; p2_v = 1'b0; p1_i = 0; p2_i = 0; p1_d = '0; p2_d = '0;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_wd[i] = '0; waitg[i] = 0;
        end
        for (int ph = 0; ph < 2; ph++)
            for (int c = 0; c < 500; c++) rand_cycle(ph, 1'b1);
        pend = '0;
        for (int c = 0; c < 3; c++) rand_cycle(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory data width.
REQ-002 Parameter ADDR_WIDTH, default 10, memory address width (1024 words).
REQ-003 Parameter NUM_REQ, default 2, number of requester ports (2..8).
REQ-004 Parameter LOCK_MAX, default 16, maximum consecutive locked beats.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  NUM_REQ  per-requester access request.
REQ-008 lock  input  NUM_REQ  per-requester request to keep the grant across beats.
REQ-009 we  input  NUM_REQ  per-requester write (1) / read (0).
REQ-010 addr  input  NUM_REQ x ADDR_WIDTH  per-requester word address.
REQ-011 wdata  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-012 gnt  output  NUM_REQ  one-hot grant; a beat is accepted when req[i] and gnt[i] are both high at a rising edge.
REQ-013 rvalid  output  NUM_REQ  one-hot read-data-valid.
REQ-014 rdata  output  DATA_WIDTH  read data, shared by all requesters, qualified by rvalid.
REQ-015 mem_en, mem_we  output  1 each  memory command.
REQ-016 mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH; mem_rdata  input  DATA_WIDTH  (memory read latency is 1 cycle, returns 0 while in reset).

Function
REQ-017 gnt SHALL be combinational from req, lock state and the priority pointer, at most one bit high, and 0 when no req is high.
REQ-018 Round-robin: with no active lock, the search SHALL start at the pointer index and move upward with wrap-around. After a grant to i, the pointer SHALL become (i+1) mod NUM_REQ. With no grant, the pointer SHALL be unchanged.
REQ-019 A beat accepted in cycle T SHALL drive mem_en=1, mem_we=we[i], mem_addr=addr[i] and mem_wdata=wdata[i] from registers in cycle T+1. With no accepted beat, mem_en and mem_we SHALL be 0.
REQ-020 For an accepted read, rvalid[i]=1 and rdata=mem_rdata SHALL appear in cycle T+2 only. A write SHALL produce no rvalid.
REQ-021 One beat SHALL be accepted per cycle for back-to-back accesses, with no bubbles. Requester identity SHALL travel through a 2-stage tag pipeline.
REQ-022 Lock FSM, states IDLE and LOCKED:
  - IDLE -> LOCKED when a beat is accepted with lock[i]=1; the owner becomes i and the beat counter is set to 1.
  - In LOCKED, only the owner SHALL be granted, and each accepted beat increments the counter.
  - LOCKED -> IDLE when the owner deasserts lock, drops req, or the counter reaches LOCK_MAX.
  - On a forced release at LOCK_MAX, the pointer SHALL be owner+1.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until granted. The arbiter is not required to tolerate req withdrawal before grant.
REQ-024 Read-after-write to the same address from consecutive grants SHALL return the new data, as ordering is preserved by the single memory port.

Reset
REQ-025 While rst_n=0 at a rising edge:
  - gnt=0, rvalid=0, rdata=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - pointer=0, FSM=IDLE, lock counter=0, tag pipeline cleared
REQ-026 Reset asserted mid-operation SHALL discard in-flight reads, with no rvalid afterwards for them. The first grant after reset release SHALL be possible in the first cycle with rst_n=1.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the default parameter values and the lock FSM state enum (ARB_IDLE, ARB_LOCKED).
REQ-028 Sub-module rr_pick (combinational round-robin select: req vector plus pointer gives a one-hot grant) SHALL be instantiated once.

Verification
REQ-029 Verification SHALL cover the following directed scenarios:
  - req=2'b11 held for 4 cycles, no lock, after reset -> gnt sequence 01,10,01,10; mem_addr follows the granted addr one cycle later.
  - Requester 0 writes 0xDEADBEEF to 0x3A, then requester 1 reads 0x3A in the next cycle -> rvalid=2'b10 two cycles after the read grant, rdata=0xDEADBEEF.
  - Requester 1 holds lock=1 and req=1 with requester 0 requesting -> exactly 16 consecutive gnt=10, then gnt=01.
  - Read granted, then rst_n=0 in the following cycle -> no rvalid, mem_en=0; after release, req0 read of 0x3A granted immediately and returns 0 (memory contents unchanged).
  - No requests for 10 cycles -> mem_en=0 and pointer unchanged; then req=2'b10 -> gnt=10 in the same cycle.
  - Random req/we/addr for 1000 cycles -> a scoreboard model matches every rdata, and no requester waits more than NUM_REQ grants (unlocked) or LOCK_MAX+NUM_REQ grants (locked).
